// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment width, polarity-neutral off pattern and hex-to-segment lookup
package seg7_pkg;
  localparam int SEG_BITS = 7;
  localparam logic [SEG_BITS-1:0] SEG_OFF = 7'h00;
  localparam logic [15:0][SEG_BITS-1:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [SEG_BITS-1:0] hex_to_seg(input logic [3:0] h);
    return HEX_SEG[h];
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-high segment pattern (bit0=a .. bit6=g)
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]          hex,
  output logic [SEG_BITS-1:0] seg
);
  assign seg = hex_to_seg(hex);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex display scanner with tear-free updates, blinking and leading-zero blanking
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [SEG_BITS-1:0]     seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(CLK_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic POL = ACTIVE_LOW != 0;
  localparam logic [SEG_BITS-1:0] SEG_IDLE = {SEG_BITS{POL}} ^ SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = {NUM_DIGITS{POL}};
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frm_q, frm_d;
  logic                  blink_q, blink_d;
  logic [VW-1:0]         pend_q, pend_d, disp_q, disp_d;
  logic [SEG_BITS-1:0]   seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  tick, wrap, frm_last, blank, lz_keep;
  logic [3:0]            nib;
  logic [SEG_BITS-1:0]   hex_seg;
  logic [NUM_DIGITS-1:0] lz_blank;
  assign tick       = presc_q == PW'(CLK_DIV - 1);
  assign wrap       = tick && idx_q == IW'(NUM_DIGITS - 1);
  assign frm_last   = frm_q == FW'(BLINK_FRAMES - 1);
  assign nib        = disp_q[{idx_q, 2'b00} +: 4];
  assign frame_done = wrap;
  assign seg        = seg_q;
  assign dig_en     = dig_q;
  seg7_hex_decode u_dec (.hex(nib), .seg(hex_seg));
  // scanning from the top digit down, suppression ends at the first non-zero nibble
  always_comb begin
    lz_blank = '0;
    lz_keep  = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_keep     = lz_keep | (disp_q[4*i +: 4] != 4'h0);
      lz_blank[i] = blank_lz & ~lz_keep;
    end
  end
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = !tick ? idx_q : wrap ? '0 : idx_q + 1'b1;
    frm_d   = !wrap ? frm_q : frm_last ? '0 : frm_q + 1'b1;
    blink_d = blink_q ^ (wrap & frm_last);
    pend_d  = load ? value : pend_q;
    disp_d  = wrap ? pend_d : disp_q;
    blank   = (blink_mask[idx_q] & blink_q) | lz_blank[idx_q];
    seg_d   = {SEG_BITS{POL}} ^ (blank ? SEG_OFF : hex_seg);
    dig_d   = DIG_IDLE ^ (presc_q < PW'(DEAD_CYCLES) ? '0 : NUM_DIGITS'(1) << idx_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      blink_q <= 1'b0;
      pend_q  <= '0;
      disp_q  <= '0;
      seg_q   <= SEG_IDLE;
      dig_q   <= DIG_IDLE;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scan-driver bench against a time-indexed reference model
module tb_seg7_scan_driver;
  localparam int N = 4, CD = 8, DC = 2, BF = 2, FRAME = N * CD;
  logic clk = 0, rst_n = 0, load = 0, blank_lz = 0;
  logic [15:0] value = '0;
  logic [3:0] blink_mask = '0;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic frame_done;
  int n_cmp = 0, n_bad = 0, t = 0;
  logic [15:0] m_pend = '0, m_disp = '0;
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  always #5 clk = ~clk;
  seg7_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
    .blink_mask(blink_mask), .seg(seg), .dig_en(dig_en), .frame_done(frame_done)
  );
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
    end
  endtask
  // output expected one cycle after model time t, derived purely from elapsed cycles
  task automatic expect_out(output logic [6:0] es, output logic [3:0] ed);
    int idx, hi;
    logic [3:0] nb;
    bit phase, blank;
    idx   = (t / CD) % N;
    phase = (((t / FRAME) / BF) % 2) == 1;
    nb    = m_disp[4*idx +: 4];
    hi    = 0;
    for (int i = 0; i < N; i++) if (m_disp[4*i +: 4] != 4'h0) hi = i;
    blank = (blink_mask[idx] && phase) || (blank_lz && idx > hi);
    es    = ~(blank ? 7'h00 : lut[nb]);
    ed    = (t % CD < DC) ? 4'hF : ~(4'b0001 << idx);
  endtask
  task automatic step(input logic ld, input logic [15:0] v, input logic blz, input logic [3:0] bm);
    logic [6:0] es;
    logic [3:0] ed;
    load = ld; value = v; blank_lz = blz; blink_mask = bm;
    expect_out(es, ed);
    if (ld) m_pend = v;
    if (t % FRAME == FRAME - 1) m_disp = m_pend;
    @(posedge clk);
    #1;
    check("seg", {9'd0, seg}, {9'd0, es});
    check("dig_en", {12'd0, dig_en}, {12'd0, ed});
    t++;
    check("frame_done", {15'd0, frame_done}, {15'd0, t % FRAME == FRAME - 1});
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, value, blank_lz, blink_mask);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", {9'd0, seg}, 16'h007F);
    check("rst_dig_en", {12'd0, dig_en}, 16'h000F);
    check("rst_frame_done", {15'd0, frame_done}, 16'h0000);
    @(negedge clk);
    rst_n = 1; t = 0;
    step(1'b1, 16'h1A3F, 1'b0, 4'h0);
    idle(2 * FRAME);
    idle(5);
    step(1'b1, 16'h1234, 1'b0, 4'h0);
    idle(3);
    step(1'b1, 16'h5678, 1'b0, 4'h0);
    idle(2 * FRAME);
    step(1'b1, 16'h0040, 1'b1, 4'h0);
    idle(2 * FRAME);
    step(1'b1, 16'h0000, 1'b1, 4'h0);
    idle(2 * FRAME);
    step(1'b1, 16'h9876, 1'b0, 4'b0010);
    idle(8 * FRAME);
    while (t % FRAME != FRAME - 1) step(1'b0, value, 1'b0, 4'h0);
    step(1'b1, 16'hBEEF, 1'b0, 4'h0);
    idle(FRAME);
    for (int k = 0; k < 2500; k++)
      step($urandom_range(0, 15) == 0, 16'($urandom),
           ($urandom_range(0, 63) == 0) ? ~blank_lz : blank_lz,
           ($urandom_range(0, 63) == 0) ? 4'($urandom) : blink_mask);
    step(1'b1, 16'hCAFE, 1'b0, 4'h0);
    while (t % CD != 4) idle(1);
    #2;
    rst_n = 0;
    #1;
    check("async_rst_seg", {9'd0, seg}, 16'h007F);
    check("async_rst_dig_en", {12'd0, dig_en}, 16'h000F);
    check("async_rst_frame_done", {15'd0, frame_done}, 16'h0000);
    m_pend = '0; m_disp = '0;
    @(negedge clk);
    rst_n = 1; t = 0;
    idle(2 * FRAME);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
